// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side handshake bundle for ps2_rx_fifo: FIFO head data, valid/ready and occupancy.
// master = receiver driving the FIFO head, slave = consumer draining it.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    code_out;
    logic          ext_out;
    logic          brk_out;
    logic          code_valid_out;
    logic          code_ready_in;
    logic [CW-1:0] fifo_count_out;

    modport master (
        output code_out, ext_out, brk_out, code_valid_out, fifo_count_out,
        input  code_ready_in
    );

    modport slave (
        input  code_out, ext_out, brk_out, code_valid_out, fifo_count_out,
        output code_ready_in
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchroniser + deglitch filter, 11-bit framer with timeout, buffered receive FIFO.
// Optional SCANCODE_PREFIX_EN folds E0/F0 prefixes into ext/brk flags on the following byte.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          ps_data_in,
    input  logic          ps_clk_in,
    ps2_rx_fifo_if.master cons,
    output logic          parity_err_out,
    output logic          frame_err_out,
    output logic          overflow_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SCANCODE_PREFIX_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic [FW-1:0]          clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
    logic                   clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
    logic                   clk_prev_q, fall;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   par_err_d, frm_err_d, ovf_d, good;
    logic                   push, pop, wr_en;
    logic [EW-1:0]          push_data, head;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    // Filtered lines move only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps_clk_in};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps_data_in};
        clk_cnt_d   = '0;
        clk_filt_d  = clk_filt_q;
        data_cnt_d  = '0;
        data_filt_d = data_filt_q;
        if (clk_sync_q[SYNC_STAGES-1] != clk_filt_q) begin
            if (clk_cnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = ~clk_filt_q;
            else                                  clk_cnt_d  = clk_cnt_q + FW'(1);
        end
        if (data_sync_q[SYNC_STAGES-1] != data_filt_q) begin
            if (data_cnt_q == FW'(FILTER_LEN - 1)) data_filt_d = ~data_filt_q;
            else                                   data_cnt_d  = data_cnt_q + FW'(1);
        end
    end

    assign fall = clk_prev_q & ~clk_filt_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        good      = 1'b0;
        // A fall event always beats the timeout, so the two branches never collide.
        if (state_q == S_IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d     = '0;
            state_d   = S_IDLE;
            frm_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_filt_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_filt_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = data_filt_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!data_filt_q)             frm_err_d = 1'b1;
                    else if (!(^shift_q ^ par_q)) par_err_d = 1'b1;
                    else                          good      = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef SCANCODE_PREFIX_EN
    logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push       = 1'b0;
        push_data  = {ext_pend_q, brk_pend_q, shift_q};
        if (par_err_d || frm_err_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (good) begin
            if (shift_q == 8'hE0)      ext_pend_d = 1'b1;
            else if (shift_q == 8'hF0) brk_pend_d = 1'b1;
            else begin
                push       = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end
`else
    always_comb begin
        push      = good;
        push_data = shift_q;
    end
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop      = (count_q != '0) && cons.code_ready_in;
        wr_en    = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
        ovf_d    = push && !wr_en;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop);
        head     = mem_q[rd_ptr_q];
    end

    assign cons.code_valid_out = (count_q != '0);
    assign cons.code_out       = cons.code_valid_out ? head[7:0] : 8'h00;
    assign cons.fifo_count_out = count_q;
`ifdef SCANCODE_PREFIX_EN
    assign cons.ext_out = cons.code_valid_out & head[9];
    assign cons.brk_out = cons.code_valid_out & head[8];
`else
    assign cons.ext_out = 1'b0;
    assign cons.brk_out = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clk_sync_q     <= '1;
            data_sync_q    <= '1;
            clk_cnt_q      <= '0;
            data_cnt_q     <= '0;
            clk_filt_q     <= 1'b1;
            data_filt_q    <= 1'b1;
            clk_prev_q     <= 1'b1;
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            par_q          <= 1'b0;
            tmo_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            parity_err_out <= 1'b0;
            frame_err_out  <= 1'b0;
            overflow_out   <= 1'b0;
        end else begin
            clk_sync_q     <= clk_sync_d;
            data_sync_q    <= data_sync_d;
            clk_cnt_q      <= clk_cnt_d;
            data_cnt_q     <= data_cnt_d;
            clk_filt_q     <= clk_filt_d;
            data_filt_q    <= data_filt_d;
            clk_prev_q     <= clk_filt_q;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            tmo_q          <= tmo_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            parity_err_out <= par_err_d;
            frame_err_out  <= frm_err_d;
            overflow_out   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: framing, parity/stop/timeout errors, glitch filter,
// FIFO overflow/order, prefix folding (SCANCODE_PREFIX_EN) and asynchronous reset.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int HP    = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps_clk = 1'b1;
    logic ps_data = 1'b1;
    logic perr, ferr, ovf;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(
        .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .ps_data_in(ps_data), .ps_clk_in(ps_clk),
        .cons(bus), .parity_err_out(perr), .frame_err_out(ferr), .overflow_out(ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;

    always @(negedge clk) begin
        if (perr) n_perr++;
        if (ferr) n_ferr++;
        if (ovf)  n_ovf++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps_bit(input logic b, input bit glitch);
        ps_data = b;
        wait_cyc(HP / 2);
        ps_clk = 1'b0;
        wait_cyc(HP);
        ps_clk = 1'b1;
        if (glitch) begin
            wait_cyc(3);
            ps_clk = 1'b0;
            wait_cyc(2);
            ps_clk = 1'b1;
            wait_cyc(HP / 2 - 5);
        end else begin
            wait_cyc(HP / 2);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_at);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps_bit(fr[i], (i == glitch_at));
        ps_data = 1'b1;
        wait_cyc(4);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] c, input logic e, input logic k);
        check({tag, "_valid"}, 32'(bus.code_valid_out), 32'd1);
        check({tag, "_code"}, 32'(bus.code_out), 32'(c));
        check({tag, "_ext"}, 32'(bus.ext_out), 32'(e));
        check({tag, "_brk"}, 32'(bus.brk_out), 32'(k));
        bus.code_ready_in = 1'b1;
        wait_cyc(1);
        bus.code_ready_in = 1'b0;
    endtask

    initial begin
        bus.code_ready_in = 1'b0;
        wait_cyc(3);
        check("rst_valid", 32'(bus.code_valid_out), 32'd0);
        check("rst_code",  32'(bus.code_out), 32'd0);
        check("rst_count", 32'(bus.fifo_count_out), 32'd0);
        check("rst_errs",  32'({perr, ferr, ovf, bus.ext_out, bus.brk_out}), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Basic good frame, then drain
        send(8'h1C, 1'b0, 1'b0, -1);
        check("f1c_count", 32'(bus.fifo_count_out), 32'd1);
        pop_check("f1c", 8'h1C, 1'b0, 1'b0);
        check("f1c_drained", 32'(bus.fifo_count_out), 32'd0);
        check("f1c_code0", 32'(bus.code_out), 32'd0);
        bus.code_ready_in = 1'b1;
        wait_cyc(2);
        bus.code_ready_in = 1'b0;
        check("pop_empty_count", 32'(bus.fifo_count_out), 32'd0);

        // Parity error then recovery
        send(8'h1C, 1'b1, 1'b0, -1);
        check("par_pulses", 32'(n_perr), 32'd1);
        check("par_count", 32'(bus.fifo_count_out), 32'd0);
        send(8'h1C, 1'b0, 1'b0, -1);
        check("par_rec_count", 32'(bus.fifo_count_out), 32'd1);
        pop_check("par_rec", 8'h1C, 1'b0, 1'b0);

        // Stop bit error, and bad start (data high on first fall)
        send(8'h2A, 1'b0, 1'b1, -1);
        check("stop_ferr", 32'(n_ferr), 32'd1);
        check("stop_count", 32'(bus.fifo_count_out), 32'd0);
        check("stop_no_perr", 32'(n_perr), 32'd1);
        ps_bit(1'b1, 1'b0);
        wait_cyc(8);
        check("badstart_ferr", 32'(n_ferr), 32'd2);

        // Overflow on a 4-deep FIFO
        send(8'h11, 1'b0, 1'b0, -1);
        send(8'h22, 1'b0, 1'b0, -1);
        send(8'h33, 1'b0, 1'b0, -1);
        send(8'h44, 1'b0, 1'b0, -1);
        check("full_count", 32'(bus.fifo_count_out), 32'd4);
        check("full_no_ovf", 32'(n_ovf), 32'd0);
        send(8'h55, 1'b0, 1'b0, -1);
        check("ovf_pulse", 32'(n_ovf), 32'd1);
        check("ovf_count", 32'(bus.fifo_count_out), 32'd4);
        pop_check("ord0", 8'h11, 1'b0, 1'b0);
        pop_check("ord1", 8'h22, 1'b0, 1'b0);
        pop_check("ord2", 8'h33, 1'b0, 1'b0);
        pop_check("ord3", 8'h44, 1'b0, 1'b0);
        check("ovf_drained", 32'(bus.fifo_count_out), 32'd0);

        // Timeout: start + 3 data bits, then the clock stays high
        ps_bit(1'b0, 1'b0);
        ps_bit(1'b0, 1'b0);
        ps_bit(1'b0, 1'b0);
        ps_bit(1'b1, 1'b0);
        ps_data = 1'b1;
        wait_cyc(100);
        check("tmo_early", 32'(n_ferr), 32'd2);
        wait_cyc(150);
        check("tmo_ferr", 32'(n_ferr), 32'd3);
        check("tmo_count", 32'(bus.fifo_count_out), 32'd0);
        send(8'h1C, 1'b0, 1'b0, -1);
        check("tmo_rec_count", 32'(bus.fifo_count_out), 32'd1);
        pop_check("tmo_rec", 8'h1C, 1'b0, 1'b0);

        // Two-cycle glitch on the clock in the middle of a frame
        send(8'h1C, 1'b0, 1'b0, 4);
        check("glitch_count", 32'(bus.fifo_count_out), 32'd1);
        check("glitch_errs", 32'(n_ferr + n_perr), 32'd4);
        pop_check("glitch", 8'h1C, 1'b0, 1'b0);

        // Prefix sequence E0 F0 75
        send(8'hE0, 1'b0, 1'b0, -1);
        send(8'hF0, 1'b0, 1'b0, -1);
        send(8'h75, 1'b0, 1'b0, -1);
`ifdef SCANCODE_PREFIX_EN
        check("pfx_count", 32'(bus.fifo_count_out), 32'd1);
        pop_check("pfx", 8'h75, 1'b1, 1'b1);
`else
        check("pfx_count", 32'(bus.fifo_count_out), 32'd3);
        pop_check("pfx0", 8'hE0, 1'b0, 1'b0);
        pop_check("pfx1", 8'hF0, 1'b0, 1'b0);
        pop_check("pfx2", 8'h75, 1'b0, 1'b0);
`endif
        check("pfx_drained", 32'(bus.fifo_count_out), 32'd0);

        // Reset mid-frame with data buffered
        send(8'h5A, 1'b0, 1'b0, -1);
        ps_bit(1'b0, 1'b0);
        ps_bit(1'b1, 1'b0);
        ps_data = 1'b0;
        wait_cyc(HP / 2);
        ps_clk = 1'b0;
        wait_cyc(3);
        check("pre_rst_count", 32'(bus.fifo_count_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.code_valid_out), 32'd0);
        check("midrst_count", 32'(bus.fifo_count_out), 32'd0);
        check("midrst_code", 32'(bus.code_out), 32'd0);
        check("midrst_errs", 32'({perr, ferr, ovf}), 32'd0);
        ps_clk = 1'b1;
        ps_data = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(10);
        send(8'h1C, 1'b0, 1'b0, -1);
        check("post_rst_count", 32'(bus.fifo_count_out), 32'd1);
        pop_check("post_rst", 8'h1C, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised successor to the single-byte PS/2 decoder. Synchronises and deglitches the PS/2 clock and data lines, then frames 11-bit packets with full start, odd-parity and stop checking plus an inter-bit timeout. Good bytes are buffered in a FIFO drained through a valid/ready handshake. It sits between the keyboard pins and the keystroke/game logic, so slow consumers no longer lose codes.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on ps_clk_in and ps_data_in (minimum 2).
FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered line changes.
TIMEOUT_CYCLES, 100000, clk_in cycles allowed between falling edges inside a frame.
FIFO_DEPTH, 8, number of entries in the receive FIFO (power of 2, minimum 2).

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
ps_data_in  input  1  raw PS/2 data line
ps_clk_in  input  1  raw PS/2 clock line
code_out  output  8  FIFO head scan code, valid when code_valid_out=1
ext_out  output  1  FIFO head extended flag (0 when feature disabled)
brk_out  output  1  FIFO head break/release flag (0 when feature disabled)
code_valid_out  output  1  FIFO non-empty
code_ready_in  input  1  consumer accepts head this cycle
fifo_count_out  output  $clog2(FIFO_DEPTH+1)  current occupancy
parity_err_out  output  1  one-cycle pulse: frame dropped on parity error
frame_err_out  output  1  one-cycle pulse: bad start, bad stop or timeout
overflow_out  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset (rst_n_in=0, asynchronous): synchroniser flops and filter outputs = 1 (idle bus), FSM=IDLE, FIFO empty, timeout counter=0. All outputs 0.
- Filter: the filtered line toggles only after FILTER_LEN consecutive synchronised samples at the opposite value. A fall event is a 1->0 transition of the filtered clock, one cycle wide. Each fall event samples the filtered data.
- FSM on each fall event:
  - IDLE: data=0 -> DATA with bit_cnt=0. data=1 -> stay IDLE and pulse frame_err_out.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: data=1 and (XOR of 8 data bits ^ parity)=1 -> push. Parity bad -> parity_err_out, no push. Stop bit=0 -> frame_err_out, no push (stop error takes precedence if both fail). Always -> IDLE.
- Timeout: outside IDLE, the counter increments every cycle and clears on each fall event. Reaching TIMEOUT_CYCLES -> IDLE and frame_err_out pulse, partial byte discarded. Counter held at 0 in IDLE.
- Push is registered in the cycle of the stop-bit fall event. code_valid_out/fifo_count_out reflect it on the next cycle.
- FIFO: pop when code_valid_out && code_ready_in. code_out/ext_out/brk_out show the head combinationally from storage; they are 0 when empty. Order is strictly FIFO; read and write pointers wrap modulo FIFO_DEPTH.
  - Push when full and no pop: byte dropped, overflow_out pulse, contents unchanged.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Pop when empty: ignored.
- Error pulses and overflow are single-cycle and mutually exclusive per frame.
- Reset mid-frame: partial frame lost, FIFO cleared. After release the FSM waits in IDLE for the next start bit.

Optional Feature:
Macro SCANCODE_PREFIX_EN.
- Defined: a good byte 0xE0 sets a pending ext flag and 0xF0 sets a pending brk flag; neither byte is pushed. The next good non-prefix byte is pushed as {ext,brk,code}, then both pending flags clear. Pending flags also clear on parity error, frame error or timeout.
- Undefined: every good byte is pushed unmodified, ext_out=brk_out=0, FIFO entries are 8 bits wide.

Test Plan:
- Frame 0x1C (bits 0,00111000,P=0,1) at 12.5 kHz -> after the stop fall event, next cycle code_valid_out=1, code_out=0x1C, fifo_count_out=1. Pulse ready -> count 0.
- Same frame with P=1 -> parity_err_out one pulse, fifo_count_out stays 0. A following correct 0x1C is received normally.
- FIFO_DEPTH=4, ready=0, send 0x11,0x22,0x33,0x44,0x55 -> count 4, overflow_out pulse on 0x55, pops return 0x11..0x44 in order.
- Start + 3 data bits, then ps_clk_in held high for TIMEOUT_CYCLES -> frame_err_out pulse, FSM IDLE. A subsequent 0x1C frame decodes correctly.
- FILTER_LEN=4, 2-cycle low glitch on ps_clk_in mid-frame -> no bit consumed; frame 0x1C still decodes to 0x1C.
- Send E0,F0,75 -> with SCANCODE_PREFIX_EN: one entry, code 0x75, ext=1, brk=1. Without it: three entries E0,F0,75, ext=brk=0. Assert rst_n_in mid-frame -> all outputs 0 immediately.
